// File: rtl/color_centroid_maxis.sv
// AXI-Stream RGB565 colour-window centroid finder: per-frame x/y sums and count of
// in-window pixels, divided after frame end into one centroid result per frame.
module color_centroid_maxis #(
    parameter int unsigned X_RES     = 640,
    parameter int unsigned Y_RES     = 480,
    parameter int unsigned MIN_COUNT = 16,
    localparam int unsigned XW  = $clog2(X_RES),
    localparam int unsigned YW  = $clog2(Y_RES),
    localparam int unsigned CW  = $clog2(X_RES * Y_RES + 1),
    localparam int unsigned SW  = XW + CW,
    localparam int unsigned STW = $clog2(SW + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic [15:0]   S_AXIS_VIDEO_TDATA,
    input  logic          S_AXIS_TVALID,
    output logic          S_AXIS_VIDEO_TREADY,
    input  logic          S_AXIS_VIDEO_TUSER,
    input  logic          S_AXIS_VIDEO_TLAST,
    input  logic [4:0]    i_r_min,
    input  logic [4:0]    i_r_max,
    input  logic [5:0]    i_g_min,
    input  logic [5:0]    i_g_max,
    input  logic [4:0]    i_b_min,
    input  logic [4:0]    i_b_max,
    output logic          o_valid,
    output logic          o_found,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [CW-1:0] o_count,
    output logic          o_frame_err,
    output logic          o_overrun
);

    typedef enum logic {ACC_WAIT = 1'b0, ACC_RUN = 1'b1} acc_state_e;
    typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_RUN = 2'd1, DIV_OUT = 2'd2} div_state_e;

    acc_state_e    acc_state_q, acc_state_d;
    div_state_e    div_state_q, div_state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          snap_q, snap_d;
    logic          tready_q, tready_d;
    logic          frame_err_q, frame_err_d;
    logic [SW-1:0] num_x_q, num_x_d, num_y_q, num_y_d;
    logic [CW-1:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
    logic [CW-1:0] dvs_q, dvs_d;
    logic [STW-1:0] step_q, step_d;
    logic          valid_q, valid_d, found_q, found_d, overrun_q, overrun_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic [CW-1:0] ocount_q, ocount_d;

    // Beat decode: a TUSER beat always re-anchors the frame at (0,0)
    logic          beat, start, in_frame, hit, at_eol, line_err, frame_end;
    logic [XW-1:0] bx;
    logic [YW-1:0] by;
    logic [4:0]    pix_r, pix_b;
    logic [5:0]    pix_g;

    assign pix_r     = S_AXIS_VIDEO_TDATA[15:11];
    assign pix_g     = S_AXIS_VIDEO_TDATA[10:5];
    assign pix_b     = S_AXIS_VIDEO_TDATA[4:0];
    assign hit       = (pix_r >= i_r_min) && (pix_r <= i_r_max) &&
                       (pix_g >= i_g_min) && (pix_g <= i_g_max) &&
                       (pix_b >= i_b_min) && (pix_b <= i_b_max);
    assign beat      = S_AXIS_TVALID && i_enable;
    assign start     = beat && S_AXIS_VIDEO_TUSER;
    assign in_frame  = start || (beat && (acc_state_q == ACC_RUN));
    assign bx        = start ? '0 : x_q;
    assign by        = start ? '0 : y_q;
    assign at_eol    = (bx == XW'(X_RES - 1));
    assign line_err  = in_frame && S_AXIS_VIDEO_TLAST && !at_eol;
    assign frame_end = in_frame && S_AXIS_VIDEO_TLAST && at_eol && (by == YW'(Y_RES - 1));

    // Restoring divider step, one quotient bit per clock for both axes
    logic [CW:0] sh_x, sh_y;
    logic        ge_x, ge_y, dvs_found;

    assign sh_x      = {rem_x_q, num_x_q[SW-1]};
    assign sh_y      = {rem_y_q, num_y_q[SW-1]};
    assign ge_x      = (sh_x >= {1'b0, dvs_q});
    assign ge_y      = (sh_y >= {1'b0, dvs_q});
    assign dvs_found = (dvs_q >= CW'(MIN_COUNT));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_state_q <= ACC_WAIT;
            div_state_q <= DIV_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            cnt_q       <= '0;
            snap_q      <= 1'b0;
            tready_q    <= 1'b0;
            frame_err_q <= 1'b0;
            num_x_q     <= '0;
            num_y_q     <= '0;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            dvs_q       <= '0;
            step_q      <= '0;
            valid_q     <= 1'b0;
            found_q     <= 1'b0;
            overrun_q   <= 1'b0;
            ox_q        <= '0;
            oy_q        <= '0;
            ocount_q    <= '0;
        end else begin
            acc_state_q <= acc_state_d;
            div_state_q <= div_state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            tready_q    <= tready_d;
            frame_err_q <= frame_err_d;
            num_x_q     <= num_x_d;
            num_y_q     <= num_y_d;
            rem_x_q     <= rem_x_d;
            rem_y_q     <= rem_y_d;
            dvs_q       <= dvs_d;
            step_q      <= step_d;
            valid_q     <= valid_d;
            found_q     <= found_d;
            overrun_q   <= overrun_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            ocount_q    <= ocount_d;
        end
    end

    always_comb begin
        acc_state_d = acc_state_q;
        if (!i_enable) begin
            acc_state_d = ACC_WAIT;
        end else if (in_frame) begin
            acc_state_d = (line_err || frame_end) ? ACC_WAIT : ACC_RUN;
        end
    end

    // Sums stay valid for one clock after frame end so the divider can snapshot them
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        sum_x_d     = sum_x_q;
        sum_y_d     = sum_y_q;
        cnt_d       = cnt_q;
        snap_d      = 1'b0;
        frame_err_d = 1'b0;
        tready_d    = 1'b1;
        if (!i_enable || ((acc_state_q == ACC_WAIT) && !start)) begin
            x_d     = '0;
            y_d     = '0;
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
        end else if (in_frame) begin
            sum_x_d     = (start ? '0 : sum_x_q) + (hit ? SW'(bx) : '0);
            sum_y_d     = (start ? '0 : sum_y_q) + (hit ? SW'(by) : '0);
            cnt_d       = (start ? '0 : cnt_q) + CW'(hit);
            frame_err_d = line_err || (start && (acc_state_q == ACC_RUN));
            snap_d      = frame_end;
            if (S_AXIS_VIDEO_TLAST) begin
                x_d = '0;
                y_d = by + YW'(1);
            end else begin
                x_d = bx + XW'(1);
                y_d = by;
            end
        end
    end

    always_comb begin
        div_state_d = div_state_q;
        case (div_state_q)
            DIV_IDLE: if (snap_q) div_state_d = (cnt_q >= CW'(MIN_COUNT)) ? DIV_RUN : DIV_OUT;
            DIV_RUN:  if (step_q == STW'(SW - 1)) div_state_d = DIV_OUT;
            DIV_OUT:  div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        num_x_d   = num_x_q;
        num_y_d   = num_y_q;
        rem_x_d   = rem_x_q;
        rem_y_d   = rem_y_q;
        dvs_d     = dvs_q;
        step_d    = step_q;
        valid_d   = 1'b0;
        found_d   = found_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        ocount_d  = ocount_q;
        overrun_d = snap_q && (div_state_q != DIV_IDLE);
        case (div_state_q)
            DIV_IDLE: begin
                if (snap_q) begin
                    num_x_d = sum_x_q;
                    num_y_d = sum_y_q;
                    rem_x_d = '0;
                    rem_y_d = '0;
                    dvs_d   = cnt_q;
                    step_d  = '0;
                end
            end
            DIV_RUN: begin
                rem_x_d = ge_x ? CW'(sh_x - {1'b0, dvs_q}) : CW'(sh_x);
                rem_y_d = ge_y ? CW'(sh_y - {1'b0, dvs_q}) : CW'(sh_y);
                num_x_d = {num_x_q[SW-2:0], ge_x};
                num_y_d = {num_y_q[SW-2:0], ge_y};
                step_d  = step_q + STW'(1);
            end
            DIV_OUT: begin
                valid_d  = 1'b1;
                found_d  = dvs_found;
                ox_d     = dvs_found ? num_x_q[XW-1:0] : '0;
                oy_d     = dvs_found ? num_y_q[YW-1:0] : '0;
                ocount_d = dvs_q;
            end
            default: ;
        endcase
    end

    assign S_AXIS_VIDEO_TREADY = tready_q;
    assign o_valid             = valid_q;
    assign o_found             = found_q;
    assign o_x                 = ox_q;
    assign o_y                 = oy_q;
    assign o_count             = ocount_q;
    assign o_frame_err         = frame_err_q;
    assign o_overrun           = overrun_q;

endmodule
